// File: rtl/sub_bytes_serial_if.sv
// Stream handshake bundle for the SubBytes stage: 128-bit AES state in,
// substituted state out, valid/ready on each side.
interface sub_bytes_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sub_bytes_serial.sv
// Encrypt-side SubBytes: forward AES S-box applied LANES bytes per cycle
// to a latched 128-bit state, with valid/ready on both sides.

module sbox_element (
  input  logic [7:0] data,
  output logic [7:0] out
);
  // Row r holds S(16r .. 16r+15); byte b sits at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out = SBOX_TBL[8*(255 - int'(data)) +: 8];
endmodule

module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  sub_bytes_serial_if.slave bus
);
  localparam int N     = 16 / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       data_q, data_d;
  logic               in_ready_q, out_valid_q;
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];
  int                 base;

  // Byte 0 is the most significant byte, so lane l of step cnt lives at
  // byte index cnt*LANES + l counted from the top.
  always_comb begin
    base = int'(cnt_q) * LANES;
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[8*(15 - (base + l)) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_element u_sbox (
      .data (lane_in[g]),
      .out  (lane_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            data_d  = bus.in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            data_d[8*(15 - (base + l)) +: 8] = lane_out[l];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial at LANES = 4, 1 and 16.
module tb_sub_bytes_serial;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_a     [3];
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic [127:0] in_data_a   [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] out_data_a  [3];

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    sub_bytes_serial_if bus ();
    assign bus.in_valid   = in_valid_a[g];
    assign bus.in_data    = in_data_a[g];
    assign bus.out_ready  = out_ready_a[g];
    assign in_ready_a[g]  = bus.in_ready;
    assign out_valid_a[g] = bus.out_valid;
    assign out_data_a[g]  = bus.out_data;
    sub_bytes_serial #(.LANES(LN)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_a[g]),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse and affine map, independent of the RTL table.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
             ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
      inv_m[s]  = 8'(x);
    end
  endtask

  task automatic run_block(input int d, input logic [127:0] din, input int lat_exp,
                           input string tag, output logic [127:0] dout);
    int t = 0;
    int edges;
    while (!in_ready_a[d] && t < 50) begin @(posedge clk); #1; t++; end
    in_valid_a[d] = 1'b1;
    in_data_a[d]  = din;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    edges = 1;
    while (!out_valid_a[d] && edges < 40) begin @(posedge clk); #1; edges++; end
    chk({tag, "_lat"}, 128'(edges), 128'(lat_exp));
    dout = out_data_a[d];
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[d] = 1'b0;
    chk({tag, "_drop"}, 128'(out_valid_a[d]), 128'd0);
  endtask

  localparam logic [127:0] V1_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V2_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V2_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    logic [127:0] res, cap, exp_b, rt;
    logic [127:0] outs [2];
    int acc_cyc [2];
    int out_cyc [2];
    int nacc, nout, seen;

    for (int d = 0; d < 3; d++) begin
      flush_a[d] = 1'b0; in_valid_a[d] = 1'b0; in_data_a[d] = '0; out_ready_a[d] = 1'b0;
    end
    build_model();

    // Reset behaviour
    #12;
    chk("rst_in_ready", 128'(in_ready_a[0]), 128'd0);
    chk("rst_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("rst_out_data", out_data_a[0], 128'd0);
    #1 rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", 128'(in_ready_a[0]), 128'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 128'(in_ready_a[0]), 128'd1);
    chk("rel_in_ready_l16", 128'(in_ready_a[2]), 128'd1);

    // Basic vectors at three lane counts
    run_block(0, V1_IN, 5, "v1_l4", res);  chk("v1_l4_data", res, V1_OUT);
    run_block(0, V2_IN, 5, "v2_l4", res);  chk("v2_l4_data", res, V2_OUT);
    run_block(1, V2_IN, 17, "v2_l1", res); chk("v2_l1_data", res, V2_OUT);
    run_block(2, V2_IN, 2, "v2_l16", res); chk("v2_l16_data", res, V2_OUT);
    run_block(2, V1_IN, 2, "v1_l16", res); chk("v1_l16_data", res, V1_OUT);

    // Backpressure hold in DONE
    @(posedge clk); #1;
    in_valid_a[0] = 1'b1; in_data_a[0] = V2_IN;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    for (int i = 0; i < 40 && !out_valid_a[0]; i++) begin @(posedge clk); #1; end
    chk("bp_valid", 128'(out_valid_a[0]), 128'd1);
    cap = out_data_a[0];
    chk("bp_data", cap, V2_OUT);
    for (int i = 0; i < 10; i++) begin
      in_valid_a[0] = 1'b1; in_data_a[0] = 128'hffff;
      @(posedge clk); #1;
      chk("bp_hold_valid", 128'(out_valid_a[0]), 128'd1);
      chk("bp_hold_data", out_data_a[0], cap);
      chk("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
    end
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    chk("bp_xfer_drop", 128'(out_valid_a[0]), 128'd0);
    chk("bp_xfer_idle", 128'(in_ready_a[0]), 128'd1);

    // Back-to-back blocks with in_valid held high
    outs[0] = '0; outs[1] = '0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; out_cyc[0] = 0; out_cyc[1] = 0;
    nacc = 0; nout = 0;
    in_valid_a[0] = 1'b1; in_data_a[0] = {16{8'h53}}; out_ready_a[0] = 1'b1;
    for (int cyc = 0; cyc < 40 && nout < 2; cyc++) begin
      if (in_ready_a[0] && in_valid_a[0] && nacc < 2) begin acc_cyc[nacc] = cyc; nacc++; end
      if (out_valid_a[0]) begin outs[nout] = out_data_a[0]; out_cyc[nout] = cyc; nout++; end
      @(posedge clk); #1;
      if (nacc == 1) in_data_a[0] = {16{8'h00}};
      if (nacc == 2) in_valid_a[0] = 1'b0;
    end
    in_valid_a[0] = 1'b0; out_ready_a[0] = 1'b0;
    chk("b2b_nout", 128'(nout), 128'd2);
    chk("b2b_out0", outs[0], {16{8'hed}});
    chk("b2b_out1", outs[1], {16{8'h63}});
    chk("b2b_period", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
    chk("b2b_idle_gap", 128'(acc_cyc[1] - out_cyc[0]), 128'd1);
    @(posedge clk); #1;

    // Flush at cnt==2
    in_valid_a[0] = 1'b1; in_data_a[0] = V1_IN;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_a[0] = 1'b1;
    @(posedge clk); #1;
    flush_a[0] = 1'b0;
    chk("fl_in_ready", 128'(in_ready_a[0]), 128'd1);
    chk("fl_out_valid", 128'(out_valid_a[0]), 128'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a[0]) seen++;
    end
    chk("fl_no_valid", 128'(seen), 128'd0);
    run_block(0, V2_IN, 5, "fl_next", res); chk("fl_next_data", res, V2_OUT);

    // Async reset mid-BUSY
    in_valid_a[0] = 1'b1; in_data_a[0] = V1_IN;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", 128'(in_ready_a[0]), 128'd0);
    chk("ar_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("ar_out_data", out_data_a[0], 128'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a[0]) seen++;
    end
    chk("ar_no_valid", 128'(seen), 128'd0);
    run_block(0, V2_IN, 5, "ar_next", res); chk("ar_next_data", res, V2_OUT);

    // Every byte value through the block, then back through the inverse
    for (int k = 0; k < 16; k++) begin
      logic [127:0] din;
      for (int j = 0; j < 16; j++) begin
        din[8*(15-j) +: 8] = 8'(16*k + j);
        exp_b[8*(15-j) +: 8] = sbox_m[16*k + j];
      end
      run_block(0, din, 5, $sformatf("ex%0d", k), res);
      chk($sformatf("ex%0d_data", k), res, exp_b);
      for (int j = 0; j < 16; j++) rt[8*(15-j) +: 8] = inv_m[res[8*(15-j) +: 8]];
      chk($sformatf("ex%0d_roundtrip", k), rt, din);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
